romload_stream: RTL and testbench

Buffered, parametrised ROM-loading byte streamer for the IO subsystem. The softcore writes 32-bit words through memory-mapped control, data and status registers. The block queues them in a FIFO and serialises them LSB-first onto the core's `rom_do`/`rom_do_valid` byte interface at a fixed pace. Unlike the unbuffered loader, it applies back-pressure instead of overwriting, supports partial tail words, and defers end-of-load until the stream has drained.

---
 rtl/romload_stream_if.sv | 32 +++
 rtl/romload_stream.sv | 218 +++++++++++++++++++++
 tb/tb_romload_stream.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/romload_stream_if.sv
// Register bus between the softcore and the ROM-loading byte streamer.
// The master (CPU side) selects a register and drives strobes/data. The slave
// (streamer) returns read data and a combinational stall for data writes.
interface romload_stream_if;
    logic        reg_ctrl_sel;
    logic        reg_data_sel;
    logic        reg_stat_sel;
    logic [3:0]  reg_wstrb;
    logic [31:0] reg_di;
    logic [31:0] reg_do;
    logic        reg_wait;

    modport master (
        output reg_ctrl_sel,
        output reg_data_sel,
        output reg_stat_sel,
        output reg_wstrb,
        output reg_di,
        input  reg_do,
        input  reg_wait
    );

    modport slave (
        input  reg_ctrl_sel,
        input  reg_data_sel,
        input  reg_stat_sel,
        input  reg_wstrb,
        input  reg_di,
        output reg_do,
        output reg_wait
    );
endinterface

// File: rtl/romload_stream.sv
// Buffered ROM-loading byte streamer.
// Words written to the data register are queued in a FIFO along with a byte
// count taken from the write strobes. The serialiser then pops them and emits
// their bytes LSB-first, one byte per BYTE_GAP cycles. Each byte's strobe
// stays high for VALID_CYCLES cycles. A full FIFO stalls the writer instead
// of dropping data. End-of-load is deferred until the stream has drained.
// Optional feature: define ROMLOAD_CHECKSUM_EN to keep a 16-bit running sum
// of the emitted bytes. The sum is visible in status bits [28:13].
module romload_stream #(
    parameter int DEPTH        = 8,
    parameter int BYTE_GAP     = 4,
    parameter int VALID_CYCLES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    romload_stream_if.slave  bus,
    output logic             rom_loading,
    output logic [7:0]       rom_do,
    output logic             rom_do_valid,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BYTE_GAP);
    localparam logic [CW-1:0] CNT_LAST  = CW'(BYTE_GAP - 1);
    localparam logic [CW-1:0] VALID_LIM = CW'(VALID_CYCLES);

    typedef enum logic {
        S_IDLE,
        S_EMIT
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [34:0]     mem_q [DEPTH];
    logic [34:0]     mem_wdata_d;
    logic [31:0]     shift_q, shift_d;
    logic [2:0]      left_q, left_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      rom_do_q, rom_do_d;
    logic            valid_q, valid_d;
    logic            loading_q, loading_d;
    logic            pending_q, pending_d;
`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0]     csum_q, csum_d;
`endif

    logic            ctrl_wr;
    logic            data_wr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            load_word;
    logic [34:0]     head;
    logic [PW-1:0]   level;

    // Bytes to emit for a data write: only the low-aligned patterns shorten a word.
    function automatic logic [2:0] strobe_count(input logic [3:0] s);
        case (s)
            4'b0001: strobe_count = 3'd1;
            4'b0011: strobe_count = 3'd2;
            4'b0111: strobe_count = 3'd3;
            default: strobe_count = 3'd4;
        endcase
    endfunction

    assign ctrl_wr     = bus.reg_ctrl_sel && (bus.reg_wstrb != 4'b0000);
    assign data_wr     = bus.reg_data_sel && (bus.reg_wstrb != 4'b0000);
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level       = wr_ptr_q - rd_ptr_q;
    assign push        = data_wr && loading_q && !full;
    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign mem_wdata_d = {bus.reg_di, strobe_count(bus.reg_wstrb)};

    assign bus.reg_wait = data_wr && loading_q && full;
    assign busy         = !empty || (state_q != S_IDLE);
    assign rom_loading  = loading_q;
    assign rom_do       = rom_do_q;
    assign rom_do_valid = valid_q;

`ifdef ROMLOAD_CHECKSUM_EN
    assign bus.reg_do = bus.reg_stat_sel ?
                        {busy, pending_q, full, csum_q, 13'(level)} : 32'd0;
`else
    assign bus.reg_do = bus.reg_stat_sel ?
                        {busy, pending_q, full, 13'd0, 16'(level)} : 32'd0;
`endif

    // Next-state logic: serialiser pacing, FIFO pointers, load start/finish control.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        left_d    = left_q;
        cnt_d     = cnt_q;
        rom_do_d  = rom_do_q;
        valid_d   = valid_q;
        loading_d = loading_q;
        pending_d = pending_q;
        load_word = 1'b0;
        pop       = 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
        csum_d    = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    load_word = 1'b1;
                end
            end
            S_EMIT: begin
                if (cnt_q == CNT_LAST) begin
                    if (left_q != 3'd0) begin
                        rom_do_d = shift_q[7:0];
                        shift_d  = {8'd0, shift_q[31:8]};
                        left_d   = left_q - 3'd1;
                        cnt_d    = '0;
                        valid_d  = 1'b1;
                    end else if (!empty) begin
                        load_word = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    valid_d = (cnt_d < VALID_LIM);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_word) begin
            pop      = 1'b1;
            rom_do_d = head[10:3];
            shift_d  = {8'd0, head[34:11]};
            left_d   = head[2:0] - 3'd1;
            cnt_d    = '0;
            valid_d  = 1'b1;
            state_d  = S_EMIT;
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

`ifdef ROMLOAD_CHECKSUM_EN
        if ((state_d == S_EMIT) && (cnt_d == '0)) begin
            csum_d = csum_q + 16'(rom_do_d);
        end
`endif

        if (pending_q && empty && (state_q == S_IDLE)) begin
            loading_d = 1'b0;
            pending_d = 1'b0;
        end

        if (ctrl_wr) begin
            if ((bus.reg_di[7:0] == 8'd1) && !loading_q) begin
                loading_d = 1'b1;
                pending_d = 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
                csum_d    = 16'd0;
`endif
            end else if (bus.reg_di[7:0] == 8'd0) begin
                pending_d = 1'b1;
            end
        end
    end

    // Register all control state; synchronous reset discards any queued words.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            shift_q   <= '0;
            left_q    <= '0;
            cnt_q     <= '0;
            rom_do_q  <= '0;
            valid_q   <= 1'b0;
            loading_q <= 1'b0;
            pending_q <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            shift_q   <= shift_d;
            left_q    <= left_d;
            cnt_q     <= cnt_d;
            rom_do_q  <= rom_do_d;
            valid_q   <= valid_d;
            loading_q <= loading_d;
            pending_q <= pending_d;
`ifdef ROMLOAD_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    // FIFO storage needs no reset because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata_d;
        end
    end

endmodule

// File: tb/tb_romload_stream.sv
// Testbench for romload_stream. Directed register writes push the bytes they
// should produce into a scoreboard queue. An independent monitor pops and
// compares on every rising edge of rom_do_valid.
module tb_romload_stream;

    localparam int DEPTH        = 8;
    localparam int BYTE_GAP     = 4;
    localparam int VALID_CYCLES = 2;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       rom_loading;
    logic [7:0] rom_do;
    logic       rom_do_valid;
    logic       busy;

    romload_stream_if bus();

    romload_stream #(
        .DEPTH        (DEPTH),
        .BYTE_GAP     (BYTE_GAP),
        .VALID_CYCLES (VALID_CYCLES)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .rom_loading  (rom_loading),
        .rom_do       (rom_do),
        .rom_do_valid (rom_do_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] sb [$];
    int         rise_cyc [$];
    int         cyc = 0;
    logic       prev_valid = 1'b0;
    int         run_len = 0;
    logic [7:0] exp_byte;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int strbBytes(input logic [3:0] s);
        case (s)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b0111: return 3;
            default: return 4;
        endcase
    endfunction

    // Status bits whose value the bench predicts (checksum field is masked out).
    function automatic logic [31:0] stMask();
`ifdef ROMLOAD_CHECKSUM_EN
        return 32'hE000_1FFF;
`else
        return 32'hFFFF_FFFF;
`endif
    endfunction

    // Monitor: compare each new byte against the scoreboard and check strobe width.
    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            prev_valid = 1'b0;
            run_len    = 0;
        end else begin
            if (rom_do_valid && !prev_valid) begin
                rise_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_byte: got 0x%02h, expected no byte", rom_do);
                end else begin
                    exp_byte = sb.pop_front();
                    checkOutput("stream_byte", 32'(rom_do), 32'(exp_byte));
                end
                run_len = 1;
            end else if (rom_do_valid) begin
                run_len++;
            end else if (prev_valid) begin
                checkOutput("valid_width", 32'(run_len), 32'(VALID_CYCLES));
            end
            prev_valid = rom_do_valid;
        end
    end

    task automatic idleBus();
        bus.reg_ctrl_sel = 1'b0;
        bus.reg_data_sel = 1'b0;
        bus.reg_stat_sel = 1'b0;
        bus.reg_wstrb    = 4'b0000;
        bus.reg_di       = 32'd0;
    endtask

    task automatic syncDrive();
        @(posedge clk);
        #1;
    endtask

    // kind 0 = control write, 1 = data write; returns the number of stalled cycles.
    task automatic applyStimulus(input int kind, input logic [3:0] strb, input logic [31:0] d,
                                 input bit expect_bytes, output int waited);
        waited = 0;
        bus.reg_ctrl_sel = (kind == 0);
        bus.reg_data_sel = (kind == 1);
        bus.reg_wstrb    = strb;
        bus.reg_di       = d;
        @(negedge clk);
        while (bus.reg_wait && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) checkOutput("wait_timeout", 32'(waited), 32'd0);
        if (expect_bytes) begin
            for (int i = 0; i < strbBytes(strb); i++) sb.push_back(d[8*i +: 8]);
        end
        syncDrive();
        idleBus();
    endtask

    task automatic statusRead(output logic [31:0] v);
        bus.reg_stat_sel = 1'b1;
        bus.reg_wstrb    = 4'b0000;
        @(negedge clk);
        v = bus.reg_do;
        syncDrive();
        bus.reg_stat_sel = 1'b0;
    endtask

    // Returns at the first negedge where the block is no longer busy.
    task automatic waitIdle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 600) begin
            n++;
            @(negedge clk);
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    int          w;
    int          waits [10];
    logic [31:0] st;
    logic [31:0] word;
    logic [15:0] pat;

    initial begin
        idleBus();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.reg_stat_sel = 1'b1;
        @(negedge clk);
        checkOutput("rst_loading", 32'(rom_loading), 32'd0);
        checkOutput("rst_rom_do", 32'(rom_do), 32'd0);
        checkOutput("rst_valid", 32'(rom_do_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wait", 32'(bus.reg_wait), 32'd0);
        checkOutput("rst_status", bus.reg_do, 32'd0);
        syncDrive();
        idleBus();
        resetn = 1'b1;
        syncDrive();

        $display("[TB] single word latency and pacing");
        applyStimulus(0, 4'hF, 32'd1, 1'b0, w);
        applyStimulus(1, 4'hF, 32'h4433_2211, 1'b1, w);
        @(negedge clk);
        checkOutput("lat_pre_valid", 32'(rom_do_valid), 32'd0);
        @(negedge clk);
        checkOutput("lat_first_valid", 32'(rom_do_valid), 32'd1);
        checkOutput("lat_first_byte", 32'(rom_do), 32'h11);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        pat = '0;
        pat[0] = rom_do_valid;
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            pat[k] = rom_do_valid;
        end
        checkOutput("valid_pattern", 32'(pat), 32'h3333);
        waitIdle("drain_t1");
        syncDrive();
        checkOutput("t1_all_bytes", 32'(sb.size()), 32'd0);

        $display("[TB] back-pressure with a full FIFO");
        rise_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            word = 32'h1312_1110 + 32'h0404_0404 * i;
            applyStimulus(1, 4'hF, word, 1'b1, waits[i]);
        end
        statusRead(st);
        checkOutput("t2_status_full", st & stMask(), 32'hA000_0008 & stMask());
        checkOutput("t2_w8_no_stall", 32'(waits[8]), 32'd0);
        checkOutput("t2_w9_stall", 32'(waits[9]), 32'd9);
        waitIdle("drain_t2");
        syncDrive();
        checkOutput("t2_byte_count", 32'(rise_cyc.size()), 32'd40);
        if (rise_cyc.size() == 40)
            checkOutput("t2_span", 32'(rise_cyc[39] - rise_cyc[0]), 32'd156);

        $display("[TB] partial tail word");
        rise_cyc.delete();
        applyStimulus(1, 4'b0111, 32'h00CC_BBAA, 1'b1, w);
        waitIdle("drain_t3");
        syncDrive();
        checkOutput("t3_bytes", 32'(rise_cyc.size()), 32'd3);
        statusRead(st);
        checkOutput("t3_status_idle", st & stMask(), 32'd0);

        $display("[TB] deferred finish");
        applyStimulus(1, 4'hF, 32'h8765_4321, 1'b1, w);
        applyStimulus(1, 4'hF, 32'h0FED_CBA9, 1'b1, w);
        applyStimulus(0, 4'hF, 32'd0, 1'b0, w);
        statusRead(st);
        checkOutput("t4_pending", 32'(st[30]), 32'd1);
        checkOutput("t4_busy", 32'(st[31]), 32'd1);
        checkOutput("t4_loading_mid", 32'(rom_loading), 32'd1);
        waitIdle("drain_t4");
        checkOutput("fin_hold", 32'(rom_loading), 32'd1);
        @(negedge clk);
        checkOutput("fin_clear", 32'(rom_loading), 32'd0);
        syncDrive();
        statusRead(st);
        checkOutput("t4_status_done", st & stMask(), 32'd0);

        $display("[TB] data write while not loading");
        rise_cyc.delete();
        applyStimulus(1, 4'hF, 32'hDEAD_BEEF, 1'b0, w);
        checkOutput("t5_no_wait", 32'(w), 32'd0);
        repeat (12) syncDrive();
        checkOutput("t5_no_bytes", 32'(rise_cyc.size()), 32'd0);
        statusRead(st);
        checkOutput("t5_status", st & stMask(), 32'd0);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 4'hF, 32'd1, 1'b0, w);
        applyStimulus(1, 4'hF, 32'h5566_7788, 1'b1, w);
        applyStimulus(1, 4'hF, 32'h99AA_BBCC, 1'b1, w);
        repeat (6) syncDrive();
        resetn = 1'b0;
        sb.delete();
        bus.reg_stat_sel = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mrst_loading", 32'(rom_loading), 32'd0);
        checkOutput("mrst_rom_do", 32'(rom_do), 32'd0);
        checkOutput("mrst_valid", 32'(rom_do_valid), 32'd0);
        checkOutput("mrst_busy", 32'(busy), 32'd0);
        checkOutput("mrst_status", bus.reg_do, 32'd0);
        syncDrive();
        idleBus();
        resetn = 1'b1;
        rise_cyc.delete();
        repeat (10) syncDrive();
        checkOutput("mrst_discarded", 32'(rise_cyc.size()), 32'd0);

`ifdef ROMLOAD_CHECKSUM_EN
        $display("[TB] checksum");
        applyStimulus(0, 4'hF, 32'd1, 1'b0, w);
        applyStimulus(1, 4'b0111, 32'h0002_FFFF, 1'b1, w);
        waitIdle("drain_t7");
        syncDrive();
        statusRead(st);
        checkOutput("csum_sum", 32'(st[28:13]), 32'h0200);
        applyStimulus(0, 4'hF, 32'd0, 1'b0, w);
        repeat (4) syncDrive();
        applyStimulus(0, 4'hF, 32'd1, 1'b0, w);
        statusRead(st);
        checkOutput("csum_clear", 32'(st[28:13]), 32'd0);
`endif

        repeat (4) syncDrive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends even if a wait loop misbehaves.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
